hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the 2-bit forwarding selects that drive the EX-stage 3:1 operand muxes, plus stall and flush controls for IF, ID and EX.
- Keeps its own shadow pipeline of destination-register and write-enable tags (ID->EX->MEM->WB).
- All forwarding decisions come from registered state; stall and flush come from ID inputs and the registered state.

Parameters:
- REG_ADDR_W, 5, register index width.
- ZERO_REG, 1, when 1 register x0 never forwards and never causes a stall.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rs1_d  in  REG_ADDR_W  source 1 index of the instruction in ID.
- rs2_d  in  REG_ADDR_W  source 2 index of the instruction in ID.
- rd_d  in  REG_ADDR_W  destination index of the instruction in ID.
- regwrite_d  in  1  ID instruction writes rd.
- load_d  in  1  ID instruction is a load (result available only in WB).
- pc_src_e  in  1  branch/jump taken, resolved in EX.
- forward_a_e  out  2  select for EX operand A mux.
- forward_b_e  out  2  select for EX operand B mux.
- stall_f  out  1  hold the PC register.
- stall_d  out  1  hold the IF/ID register.
- flush_d  out  1  clear the IF/ID register.
- flush_e  out  1  clear the ID/EX register (insert bubble).

Behaviour:
- Reset (async, rst=1): all shadow registers cleared. All outputs forced to 0 while rst is high, regardless of inputs.
- Shadow registers:
  - EX stage: rs1_e, rs2_e, rd_e, regwrite_e, load_e.
  - MEM stage: rd_m, regwrite_m.
  - WB stage: rd_w, regwrite_w.
- Update on every rising clk edge (rst=0):
  - MEM stage <- EX stage.
  - WB stage <- MEM stage.
  - EX stage <- ID inputs, unless flush_e=1. With flush_e=1, EX stage <- bubble (all fields 0).
  - No enable: the shadow pipe advances every cycle. A stall holds ID externally and bubbles EX here.
- Forward select encoding (matches mux3: s[1] selects d2, else s[0] selects d1):
  - 2'b00: register-file value.
  - 2'b01: WB result.
  - 2'b10: MEM ALU result.
  - 2'b11: never driven.
- forward_a_e rule:
  - 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - else 00.
  - MEM has priority over WB (newest value wins).
- forward_b_e: same rule using rs2_e.
- With ZERO_REG=0 the rd!=0 terms are omitted.
- forward_*_e are purely functions of registered state: no combinational path from the ID inputs.
- Load-use hazard: lwstall = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). The check does not qualify on whether the ID instruction actually uses rs2.
- Outputs:
  - stall_f = stall_d = lwstall && !pc_src_e.
  - flush_d = pc_src_e.
  - flush_e = lwstall || pc_src_e.
- Simultaneous taken branch and load-use: the branch wins. No stall; flush_d=1, flush_e=1, so fetch proceeds to the target.
- Latency:
  - A load in EX produces a 1-cycle stall.
  - After the bubble, the load sits in WB when the consumer reaches EX, so the consumer gets forward=01.
- Back-to-back ALU producers: the consumer in EX sees the producer in MEM, so forward=10, with zero stall.
- rst deasserted mid-stream: the shadow pipe restarts empty, with no spurious forwards for 3 cycles.

Test Plan:
1. Reset check: assert rst with pc_src_e=1 and a load-use pattern on the inputs -> all outputs 0; after release, forward_a_e=forward_b_e=00.
2. ALU-ALU forwarding: issue add x5 (regwrite_d=1, rd_d=5), then on the next cycle rs1_d=5 -> when the consumer is in EX, forward_a_e=10. Put a nop between producer and consumer instead -> forward_a_e=01.
3. Priority: two consecutive writers of x7, then a consumer with rs2_d=7 -> forward_b_e=10 (MEM wins over WB).
4. x0 suppression: writer with rd_d=0, consumer with rs1_d=0 -> forward_a_e=00. A load to x0 followed by rs1_d=0 -> no stall.
5. Load-use: load with rd=3, next cycle rs2_d=3 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle forward_b_e=01, no stall.
6. Branch vs load-use: load-use condition and pc_src_e=1 in the same cycle -> stall_f=stall_d=0, flush_d=flush_e=1; next cycle the EX shadow is a bubble and forward selects are 00.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Forwarding selects plus stall/flush control for a 5-stage RV32I
//            pipeline, tracking rd/write-enable tags in a shadow pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit #(
   parameter int REG_ADDR_W = 5,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  regwrite_d,
   input  logic                  load_d,
   input  logic                  pc_src_e,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Shadow pipeline tags
   logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic                  regwrite_e, load_e, regwrite_m, regwrite_w;

   logic                  nz_e, nz_m, nz_w;
   logic                  hit_a_m, hit_a_w, hit_b_m, hit_b_w;
   logic [1:0]            fwd_a, fwd_b;
   logic                  lwstall;
   logic                  bubble_e;

   // x0 is hard-wired to zero, so its tags are ignored when ZERO_REG is set.
   generate
      if (ZERO_REG) begin : g_zero_guard
         assign nz_e = (rd_e != '0);
         assign nz_m = (rd_m != '0);
         assign nz_w = (rd_w != '0);
      end else begin : g_no_zero_guard
         assign nz_e = 1'b1;
         assign nz_m = 1'b1;
         assign nz_w = 1'b1;
      end
   endgenerate

   assign hit_a_m = regwrite_m && nz_m && (rd_m == rs1_e);
   assign hit_a_w = regwrite_w && nz_w && (rd_w == rs1_e);
   assign hit_b_m = regwrite_m && nz_m && (rd_m == rs2_e);
   assign hit_b_w = regwrite_w && nz_w && (rd_w == rs2_e);

   // MEM is the newer result, so it takes priority over WB.
   always_comb begin
      fwd_a = FWD_RF;
      if (hit_a_m)
         fwd_a = FWD_MEM;
      else if (hit_a_w)
         fwd_a = FWD_WB;

      fwd_b = FWD_RF;
      if (hit_b_m)
         fwd_b = FWD_MEM;
      else if (hit_b_w)
         fwd_b = FWD_WB;
   end

   assign lwstall  = load_e && nz_e && ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign bubble_e = lwstall || pc_src_e;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
         regwrite_e <= 1'b0;
         load_e     <= 1'b0;
         rd_m       <= '0;
         regwrite_m <= 1'b0;
         rd_w       <= '0;
         regwrite_w <= 1'b0;
      end else begin
         rd_w       <= rd_m;
         regwrite_w <= regwrite_m;
         rd_m       <= rd_e;
         regwrite_m <= regwrite_e;
         if (bubble_e) begin
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            regwrite_e <= 1'b0;
            load_e     <= 1'b0;
         end else begin
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            regwrite_e <= regwrite_d;
            load_e     <= load_d;
         end
      end
   end

   // A taken branch discards the stalled instruction, so it overrides the stall.
   assign forward_a_e = rst ? FWD_RF : fwd_a;
   assign forward_b_e = rst ? FWD_RF : fwd_b;
   assign stall_f     = !rst && lwstall && !pc_src_e;
   assign stall_d     = !rst && lwstall && !pc_src_e;
   assign flush_d     = !rst && pc_src_e;
   assign flush_e     = !rst && bubble_e;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// Module   : tb_hazard_fwd_unit
// Purpose  : Directed vector table, corner sequences and randomized run
//            against an instruction-history reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
   logic       regwrite_d = 1'b0, load_d = 1'b0, pc_src_e = 1'b0;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, flush_d, flush_e;

   int n_cmp = 0;
   int n_err = 0;

   hazard_fwd_unit #(.REG_ADDR_W(5), .ZERO_REG(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .rs1_d      (rs1_d),
      .rs2_d      (rs2_d),
      .rd_d       (rd_d),
      .regwrite_d (regwrite_d),
      .load_d     (load_d),
      .pc_src_e   (pc_src_e),
      .forward_a_e(forward_a_e),
      .forward_b_e(forward_b_e),
      .stall_f    (stall_f),
      .stall_d    (stall_d),
      .flush_d    (flush_d),
      .flush_e    (flush_e)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld, pc;
      logic [1:0] fa, fb;
      logic       sf, sd, fd, fe;
   } vec_t;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld;
   } instr_t;

   vec_t   tbl[27];
   instr_t hist[$];

   function automatic vec_t r(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic pc,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic fd, input logic fe);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.ld = ld; v.pc = pc;
      v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                          input logic sf, input logic sd, input logic fd, input logic fe);
      chk({tag, ".forward_a_e"}, forward_a_e, fa);
      chk({tag, ".forward_b_e"}, forward_b_e, fb);
      chk({tag, ".stall_f"}, {1'b0, stall_f}, {1'b0, sf});
      chk({tag, ".stall_d"}, {1'b0, stall_d}, {1'b0, sd});
      chk({tag, ".flush_d"}, {1'b0, flush_d}, {1'b0, fd});
      chk({tag, ".flush_e"}, {1'b0, flush_e}, {1'b0, fe});
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic pc);
      rs1_d = rs1; rs2_d = rs2; rd_d = rd; regwrite_d = rw; load_d = ld; pc_src_e = pc;
   endtask

   // Reference model: hist[2] is the instruction now in EX, hist[1] the one
   // issued before it (MEM), hist[0] the one before that (WB).
   function automatic logic [1:0] model_fwd(input logic [4:0] src);
      if (src == 5'd0) return 2'd0;
      for (int age = 1; age <= 2; age++) begin
         if (hist[2-age].rw && hist[2-age].rd == src)
            return (age == 1) ? 2'd2 : 2'd1;
      end
      return 2'd0;
   endfunction

   function automatic logic model_lwstall(input instr_t id);
      return hist[2].ld && hist[2].rd != 5'd0 && (hist[2].rd == id.rs1 || hist[2].rd == id.rs2);
   endfunction

   task automatic model_reset();
      instr_t nop;
      nop = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, ld: 1'b0};
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(nop);
   endtask

   initial begin
      instr_t id, nop, issued;
      logic   hold, lw, pc;
      logic [1:0] efa, efb;

      nop = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, ld: 1'b0};

      tbl[0]  = r(0,0,5,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[1]  = r(5,0,6,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[2]  = r(0,0,0,0,0,0, 2'd2,2'd0,0,0,0,0);
      tbl[3]  = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[4]  = r(0,0,5,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[5]  = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[6]  = r(5,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[7]  = r(0,0,0,0,0,0, 2'd1,2'd0,0,0,0,0);
      tbl[8]  = r(0,0,7,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[9]  = r(0,0,7,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[10] = r(0,7,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[11] = r(0,0,0,0,0,0, 2'd0,2'd2,0,0,0,0);
      tbl[12] = r(0,0,0,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[13] = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[14] = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[15] = r(0,0,0,1,1,0, 2'd0,2'd0,0,0,0,0);
      tbl[16] = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[17] = r(0,0,3,1,1,0, 2'd0,2'd0,0,0,0,0);
      tbl[18] = r(0,3,8,1,0,0, 2'd0,2'd0,1,1,0,1);
      tbl[19] = r(0,3,8,1,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[20] = r(0,0,0,0,0,0, 2'd0,2'd1,0,0,0,0);
      tbl[21] = r(0,0,4,1,1,0, 2'd0,2'd0,0,0,0,0);
      tbl[22] = r(4,0,0,0,0,1, 2'd0,2'd0,0,0,1,1);
      tbl[23] = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[24] = r(0,0,9,1,0,1, 2'd0,2'd0,0,0,1,1);
      tbl[25] = r(9,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);
      tbl[26] = r(0,0,0,0,0,0, 2'd0,2'd0,0,0,0,0);

      // Reset held with a branch and a load-use pattern on the inputs
      drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      chk_all("reset", 2'd0, 2'd0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk_all("post_reset", 2'd0, 2'd0, 0, 0, 0, 0);

      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].sf, tbl[i].sd,
                 tbl[i].fd, tbl[i].fe);
      end

      // Randomized run against the history model
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      hold = 1'b0;
      id = nop;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!hold) begin
            id.rs1 = 5'($urandom_range(0, 7));
            id.rs2 = 5'($urandom_range(0, 7));
            id.rd  = 5'($urandom_range(0, 7));
            id.ld  = ($urandom_range(0, 3) == 0);
            id.rw  = id.ld || ($urandom_range(0, 3) != 0);
         end
         pc  = ($urandom_range(0, 6) == 0);
         lw  = model_lwstall(id);
         efa = model_fwd(hist[2].rs1);
         efb = model_fwd(hist[2].rs2);
         drive(id.rs1, id.rs2, id.rd, id.rw, id.ld, pc);
         #1;
         chk_all($sformatf("rand%0d", c), efa, efb, lw && !pc, lw && !pc, pc, lw || pc);
         issued = (lw || pc) ? nop : id;
         hist.push_back(issued);
         void'(hist.pop_front());
         hold = lw && !pc;
      end

      // Asynchronous reset mid-stream, then the pipe must restart empty
      @(negedge clk);
      drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      chk_all("mid_reset", 2'd0, 2'd0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(5'(k + 1), 5'(k + 3), 5'd0, 1'b0, 1'b0, 1'b0);
         #1;
         chk_all($sformatf("restart%0d", k), 2'd0, 2'd0, 0, 0, 0, 0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
